mc_control_sequencer: RTL and testbench
=======================================

# mc_control_sequencer

Multi-cycle control sequencer for the MIPS datapath. It turns the 7-bit execute-state code from the instruction encoder into a cycle-by-cycle sequence of fetch, decode, execute, memory and write-back states. For each state it drives the register-load, mux-select and memory-strobe controls. Memory accesses use a wait-for-MOC handshake with a bounded timeout. The block sits between the instruction encoder (input) and the datapath/memory interface (outputs).

## Interface
- MAX_WAIT, 15: maximum consecutive wait cycles with MOC low before abort; legal range 1..255.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- State_Sel  in  7  execute-state code from the instruction encoder; sampled only in DECODE.
- MOC  in  1  memory operation complete; sampled only in wait states.
- Cond_True  in  1  branch condition result from the datapath; sampled only in branch states.
- State  out  7  current state register.
- Exec_Code  out  7  code latched in DECODE.
- MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, RF_Ld  out  1 each  register load strobes.
- PC_Sel  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = rs.
- RF_Src  out  1  register-file write source: 0 = ALU, 1 = MDR.
- MAR_Src  out  1  MAR source: 0 = PC, 1 = ALU address.
- Mem_Read, Mem_Write  out  1 each  memory strobes.
- Cond_Eval  out  1  asks the datapath to evaluate the branch condition.
- Illegal, Bus_Error  out  1 each  registered one-cycle error pulses.

## Operation
- States and transitions:
  - 0 RST → 1.
  - 1 FETCH: MAR_Ld, MAR_Src=0 → 2.
  - 2 FETCH_WAIT: Mem_Read; MOC=1 → MDR_Ld, go to 3.
  - 3 IR_LOAD: IR_Ld, PC_Ld, PC_Sel=0 → 4.
  - 4 DECODE: latch Exec_Code ← State_Sel; go to the execute state named by the code.
- ALU states 6 and 17..35: RF_Ld, RF_Src=0; one cycle → 1.
- Store:
  - 7 ST_ADDR: MAR_Ld, MAR_Src=1 → 8.
  - 8 ST_WAIT: Mem_Write until MOC → 1.
- Load:
  - 13 LD_ADDR: MAR_Ld, MAR_Src=1 → 14.
  - 14 LD_WAIT: Mem_Read; MOC=1 → MDR_Ld, go to 15.
  - 15 LD_WB: RF_Ld, RF_Src=1 → 1.
- Branches 11, 37, 39, 41, 42: Cond_Eval. Cond_True=1 → 45 BR_TAKE (PC_Ld, PC_Sel=1) → 1. Cond_True=0 → 1.
- JR 44: PC_Ld, PC_Sel=2 → 1.
- Any other code in DECODE, including 1: Illegal pulses the next cycle; go to 1. Exec_Code still holds the code.
- Wait states 2, 8, 14:
  - The wait counter clears on entry to the state.
  - MOC=1 → proceed; this takes priority even on the final allowed cycle.
  - MOC=0 with counter = MAX_WAIT-1 → Bus_Error pulses the next cycle; go to 1 with no load strobes.
  - MOC=0 otherwise → counter increments.
- Control outputs are Moore decodes of State; MDR_Ld is qualified by MOC. An unlisted State value decodes all outputs to 0 and goes to 1.

## Timing
- Reset asserted: State=0, Exec_Code=0, wait counter=0, every output 0. A mid-wait reset aborts immediately and issues no strobes.
- First FETCH occurs 1 cycle after reset deassertion.
- Minimum latency with MOC=1 in the first wait cycle:
  - ALU: 5 cycles.
  - Store: 6 cycles.
  - Load: 7 cycles.
  - Branch taken: 6 cycles; not taken: 5 cycles.
  - JR: 5 cycles.
- Each extra MOC-low cycle adds 1 cycle.
- Abort occurs after exactly MAX_WAIT consecutive MOC-low cycles in one wait state.
- Illegal and Bus_Error are high for exactly 1 cycle, aligned with the following FETCH.

## Structure
- Package mc_ctrl_pkg holds:
  - 7-bit state localparams: RST, FETCH, FETCH_WAIT, IR_LOAD, DECODE, ST_ADDR, ST_WAIT, LD_ADDR, LD_WAIT, LD_WB, BR_TAKE, JR, the branch codes and the ALU range limits.
  - PC_Sel encodings.
- Sub-module mc_wait_timer: clear/increment/expire counter, parameterised by MAX_WAIT, with width clog2(MAX_WAIT+1).

## Test plan
- Reset released, State_Sel=6, MOC=1 throughout → State sequence 1,2,3,4,6,1; RF_Ld high in cycle 5 only; Illegal=0.
- State_Sel=13, MOC low 3 cycles in LD_WAIT → sequence 1,2,3,4,13,14,14,14,14,15,1; MDR_Ld in the single MOC cycle; RF_Src=1 in 15.
- MAX_WAIT=4, MOC held 0 in FETCH_WAIT → 4 wait cycles, then Bus_Error pulses 1 cycle with State=1 and IR_Ld never asserted. Repeat with MOC=1 on the 4th wait cycle → no Bus_Error, proceeds to 3.
- State_Sel=41 with Cond_True=1 → 45, PC_Ld with PC_Sel=1. With Cond_True=0 → back to 1, PC_Ld=0.
- State_Sel=1 and State_Sel=50 in DECODE → Illegal pulse, next state 1, Exec_Code=1 and 50 respectively.
- Reset_n dropped mid-ST_WAIT (State=8) → asynchronously State=0, Mem_Write=0; after release, a normal fetch follows.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared state codes, PC source encodings and code classification
// helpers for the multi-cycle control sequencer.
package mc_ctrl_pkg;

    localparam logic [6:0] S_RST        = 7'd0;
    localparam logic [6:0] S_FETCH      = 7'd1;
    localparam logic [6:0] S_FETCH_WAIT = 7'd2;
    localparam logic [6:0] S_IR_LOAD    = 7'd3;
    localparam logic [6:0] S_DECODE     = 7'd4;
    localparam logic [6:0] S_ALU_OP     = 7'd6;
    localparam logic [6:0] S_ST_ADDR    = 7'd7;
    localparam logic [6:0] S_ST_WAIT    = 7'd8;
    localparam logic [6:0] S_BEQ        = 7'd11;
    localparam logic [6:0] S_LD_ADDR    = 7'd13;
    localparam logic [6:0] S_LD_WAIT    = 7'd14;
    localparam logic [6:0] S_LD_WB      = 7'd15;
    localparam logic [6:0] S_ALU_LO     = 7'd17;
    localparam logic [6:0] S_ALU_HI     = 7'd35;
    localparam logic [6:0] S_BNE        = 7'd37;
    localparam logic [6:0] S_BLEZ       = 7'd39;
    localparam logic [6:0] S_BGTZ       = 7'd41;
    localparam logic [6:0] S_BLTZ       = 7'd42;
    localparam logic [6:0] S_JR         = 7'd44;
    localparam logic [6:0] S_BR_TAKE    = 7'd45;

    localparam logic [1:0] PC_SEL_INC = 2'd0;
    localparam logic [1:0] PC_SEL_BR  = 2'd1;
    localparam logic [1:0] PC_SEL_RS  = 2'd2;

    function automatic logic is_alu(input logic [6:0] c);
        return (c == S_ALU_OP) || ((c >= S_ALU_LO) && (c <= S_ALU_HI));
    endfunction

    function automatic logic is_branch(input logic [6:0] c);
        return (c == S_BEQ) || (c == S_BNE) || (c == S_BLEZ) ||
               (c == S_BGTZ) || (c == S_BLTZ);
    endfunction

    // Codes that DECODE may dispatch to directly.
    function automatic logic is_legal(input logic [6:0] c);
        return is_alu(c) || is_branch(c) || (c == S_ST_ADDR) ||
               (c == S_LD_ADDR) || (c == S_JR);
    endfunction

    // Successor of a wait state once MOC arrives.
    function automatic logic [6:0] wait_exit(input logic [6:0] s);
        if (s == S_FETCH_WAIT) return S_IR_LOAD;
        if (s == S_LD_WAIT) return S_LD_WB;
        return S_FETCH;
    endfunction

endpackage

// File: rtl/mc_control_sequencer_wait_timer.sv
// Bounded wait counter for the memory handshake states.
// Expires on the last allowed MOC-low cycle.
module mc_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] LAST = W'(MAX_WAIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear has priority; increment only while still waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) cnt_d = '0;
        else if (inc_i) cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == LAST);
endmodule

// File: rtl/mc_control_sequencer.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute FSM with
// Moore control decodes and a bounded MOC handshake.
module mc_control_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [6:0] State_Sel,
    input  logic       MOC,
    input  logic       Cond_True,
    output logic [6:0] State,
    output logic [6:0] Exec_Code,
    output logic       MAR_Ld,
    output logic       MDR_Ld,
    output logic       IR_Ld,
    output logic       PC_Ld,
    output logic       RF_Ld,
    output logic [1:0] PC_Sel,
    output logic       RF_Src,
    output logic       MAR_Src,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic       Cond_Eval,
    output logic       Illegal,
    output logic       Bus_Error
);
    logic [6:0] state_q, state_d;
    logic [6:0] code_q, code_d;
    logic       ill_q, ill_d;
    logic       berr_q, berr_d;
    logic       in_wait, expire, wt_inc;

    assign in_wait = (state_q == S_FETCH_WAIT) ||
                     (state_q == S_ST_WAIT) ||
                     (state_q == S_LD_WAIT);
    assign wt_inc  = in_wait && !MOC && !expire;

    mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .clr_i    (!wt_inc),
        .inc_i    (wt_inc),
        .expire_o (expire)
    );

    // Next state, decode latch and error pulse generation.
    always_comb begin
        state_d = S_FETCH;
        code_d  = code_q;
        ill_d   = 1'b0;
        berr_d  = 1'b0;
        unique case (1'b1)
            state_q == S_FETCH:   state_d = S_FETCH_WAIT;
            in_wait: begin
                if (MOC) state_d = wait_exit(state_q);
                else if (expire) berr_d = 1'b1;
                else state_d = state_q;
            end
            state_q == S_IR_LOAD: state_d = S_DECODE;
            state_q == S_DECODE: begin
                code_d = State_Sel;
                if (is_legal(State_Sel)) state_d = State_Sel;
                else ill_d = 1'b1;
            end
            state_q == S_ST_ADDR: state_d = S_ST_WAIT;
            state_q == S_LD_ADDR: state_d = S_LD_WAIT;
            is_branch(state_q): begin
                if (Cond_True) state_d = S_BR_TAKE;
            end
            default: ;
        endcase
    end

    // Moore control decodes; MDR load waits for MOC.
    always_comb begin
        MAR_Ld    = 1'b0;
        MDR_Ld    = 1'b0;
        IR_Ld     = 1'b0;
        PC_Ld     = 1'b0;
        RF_Ld     = 1'b0;
        PC_Sel    = PC_SEL_INC;
        RF_Src    = 1'b0;
        MAR_Src   = 1'b0;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        Cond_Eval = 1'b0;
        unique case (1'b1)
            state_q == S_FETCH:      MAR_Ld = 1'b1;
            state_q == S_FETCH_WAIT: begin
                Mem_Read = 1'b1;
                MDR_Ld   = MOC;
            end
            state_q == S_IR_LOAD: begin
                IR_Ld = 1'b1;
                PC_Ld = 1'b1;
            end
            is_alu(state_q):         RF_Ld = 1'b1;
            state_q == S_ST_ADDR: begin
                MAR_Ld  = 1'b1;
                MAR_Src = 1'b1;
            end
            state_q == S_ST_WAIT:    Mem_Write = 1'b1;
            state_q == S_LD_ADDR: begin
                MAR_Ld  = 1'b1;
                MAR_Src = 1'b1;
            end
            state_q == S_LD_WAIT: begin
                Mem_Read = 1'b1;
                MDR_Ld   = MOC;
            end
            state_q == S_LD_WB: begin
                RF_Ld  = 1'b1;
                RF_Src = 1'b1;
            end
            is_branch(state_q):      Cond_Eval = 1'b1;
            state_q == S_BR_TAKE: begin
                PC_Ld  = 1'b1;
                PC_Sel = PC_SEL_BR;
            end
            state_q == S_JR: begin
                PC_Ld  = 1'b1;
                PC_Sel = PC_SEL_RS;
            end
            default: ;
        endcase
    end

    // State, latched code and registered error pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_RST;
            code_q  <= '0;
            ill_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ill_q   <= ill_d;
            berr_q  <= berr_d;
        end
    end

    assign State     = state_q;
    assign Exec_Code = code_q;
    assign Illegal   = ill_q;
    assign Bus_Error = berr_q;
endmodule

// File: tb/tb_mc_control_sequencer.sv
// Self-checking bench for mc_control_sequencer: an instruction-level
// model expands each instruction into its expected per-cycle trace.
module tb_mc_control_sequencer;
    localparam int MW = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic [6:0] State_Sel = '0;
    logic       MOC = 1'b0;
    logic       Cond_True = 1'b0;
    logic [6:0] State, Exec_Code;
    logic       MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, RF_Ld;
    logic [1:0] PC_Sel;
    logic       RF_Src, MAR_Src, Mem_Read, Mem_Write, Cond_Eval;
    logic       Illegal, Bus_Error;

    always #5 Clk = ~Clk;

    mc_control_sequencer #(.MAX_WAIT(MW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .State_Sel(State_Sel),
        .MOC(MOC), .Cond_True(Cond_True), .State(State),
        .Exec_Code(Exec_Code), .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld),
        .IR_Ld(IR_Ld), .PC_Ld(PC_Ld), .RF_Ld(RF_Ld), .PC_Sel(PC_Sel),
        .RF_Src(RF_Src), .MAR_Src(MAR_Src), .Mem_Read(Mem_Read),
        .Mem_Write(Mem_Write), .Cond_Eval(Cond_Eval),
        .Illegal(Illegal), .Bus_Error(Bus_Error)
    );

    localparam logic [13:0] M_MAR  = 14'd1 << 13;
    localparam logic [13:0] M_MDR  = 14'd1 << 12;
    localparam logic [13:0] M_IR   = 14'd1 << 11;
    localparam logic [13:0] M_PC   = 14'd1 << 10;
    localparam logic [13:0] M_RF   = 14'd1 << 9;
    localparam logic [13:0] M_PCRS = 14'd1 << 8;
    localparam logic [13:0] M_PCBR = 14'd1 << 7;
    localparam logic [13:0] M_RFS  = 14'd1 << 6;
    localparam logic [13:0] M_MARS = 14'd1 << 5;
    localparam logic [13:0] M_MR   = 14'd1 << 4;
    localparam logic [13:0] M_MW   = 14'd1 << 3;
    localparam logic [13:0] M_CE   = 14'd1 << 2;
    localparam logic [13:0] M_ILL  = 14'd1 << 1;
    localparam logic [13:0] M_BE   = 14'd1;

    logic [13:0] act_ctl;
    assign act_ctl = {MAR_Ld, MDR_Ld, IR_Ld, PC_Ld, RF_Ld, PC_Sel,
                      RF_Src, MAR_Src, Mem_Read, Mem_Write, Cond_Eval,
                      Illegal, Bus_Error};

    typedef struct {
        logic [6:0]  st;
        logic [13:0] ctl;
        logic [6:0]  code;
        logic        moc;
        logic        cond;
        logic [6:0]  sel;
    } step_t;

    step_t      q[$];
    int         errors = 0;
    int         checks = 0;
    logic [6:0] exp_code = '0;
    bit         pend_ill = 0;
    bit         pend_be = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rs();
        return 7'($urandom);
    endfunction

    // 0 illegal, 1 ALU, 2 store, 3 load, 4 branch, 5 JR
    function automatic int kind(input logic [6:0] c);
        if (c == 7'd6 || (c >= 7'd17 && c <= 7'd35)) return 1;
        if (c == 7'd7) return 2;
        if (c == 7'd13) return 3;
        if (c == 7'd11 || c == 7'd37 || c == 7'd39 ||
            c == 7'd41 || c == 7'd42) return 4;
        if (c == 7'd44) return 5;
        return 0;
    endfunction

    task automatic push(input logic [6:0] st, input logic [13:0] ctl,
                        input logic moc, input logic cond,
                        input logic [6:0] sel);
        step_t s;
        s.st = st;
        s.ctl = ctl;
        if (st == 7'd1) begin
            if (pend_ill) s.ctl = s.ctl | M_ILL;
            if (pend_be) s.ctl = s.ctl | M_BE;
            pend_ill = 0;
            pend_be = 0;
        end
        s.code = exp_code;
        s.moc = moc;
        s.cond = cond;
        s.sel = sel;
        q.push_back(s);
    endtask

    // w MOC-low cycles then MOC high; w >= MW means abort after MW.
    task automatic wait_ph(input logic [6:0] st, input logic [13:0] ctl,
                           input bit mdr, input int w, output bit ab);
        int n;
        n = (w >= MW) ? MW : w;
        for (int i = 0; i < n; i++) push(st, ctl, 1'b0, rb(), rs());
        if (w >= MW) begin
            pend_be = 1;
            ab = 1;
        end else begin
            push(st, ctl | (mdr ? M_MDR : 14'd0), 1'b1, rb(), rs());
            ab = 0;
        end
    endtask

    task automatic gen(input logic [6:0] sel, input logic cond,
                       input int wf, input int wm);
        bit ab;
        push(7'd1, M_MAR, rb(), rb(), rs());
        wait_ph(7'd2, M_MR, 1, wf, ab);
        if (ab) return;
        push(7'd3, M_IR | M_PC, rb(), rb(), rs());
        push(7'd4, 14'd0, rb(), rb(), sel);
        exp_code = sel;
        case (kind(sel))
            1: push(sel, M_RF, rb(), rb(), rs());
            2: begin
                push(7'd7, M_MAR | M_MARS, rb(), rb(), rs());
                wait_ph(7'd8, M_MW, 0, wm, ab);
            end
            3: begin
                push(7'd13, M_MAR | M_MARS, rb(), rb(), rs());
                wait_ph(7'd14, M_MR, 1, wm, ab);
                if (!ab) push(7'd15, M_RF | M_RFS, rb(), rb(), rs());
            end
            4: begin
                push(sel, M_CE, rb(), cond, rs());
                if (cond) push(7'd45, M_PC | M_PCBR, rb(), rb(), rs());
            end
            5: push(7'd44, M_PC | M_PCRS, rb(), rb(), rs());
            default: pend_ill = 1;
        endcase
    endtask

    task automatic step_dut(input step_t s, output logic [27:0] obs);
        MOC = s.moc;
        Cond_True = s.cond;
        State_Sel = s.sel;
        @(negedge Clk);
        obs = {State, act_ctl, Exec_Code};
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b1;
        #2 Reset_n = 1'b0;
        MOC = 1'b1;
        State_Sel = 7'd6;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({State, act_ctl, Exec_Code} !== 28'd0) begin
            errors++;
            $display("FAIL reset: st=%0d ctl=%b code=%0d want all 0",
                     State, act_ctl, Exec_Code);
        end
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_alu();
        step_t s;
        logic [27:0] obs;
        gen(7'd6, 1'b0, 0, 0);
        gen(7'(17 + $urandom_range(0, 18)), 1'b0, 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            step_dut(s, obs);
            checks++;
            if (obs !== {s.st, s.ctl, s.code}) begin
                errors++;
                $display("FAIL alu: got st=%0d ctl=%b code=%0d want st=%0d ctl=%b code=%0d",
                         obs[27:21], obs[20:7], obs[6:0], s.st, s.ctl, s.code);
            end
        end
    endtask

    task automatic test_load_store();
        step_t s;
        logic [27:0] obs;
        gen(7'd13, 1'b0, 0, 3);
        gen(7'd7, 1'b0, 0, 0);
        gen(7'd7, 1'b0, 2, 2);
        gen(7'd13, 1'b0, 0, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            step_dut(s, obs);
            checks++;
            if (obs !== {s.st, s.ctl, s.code}) begin
                errors++;
                $display("FAIL ldst: got st=%0d ctl=%b code=%0d want st=%0d ctl=%b code=%0d",
                         obs[27:21], obs[20:7], obs[6:0], s.st, s.ctl, s.code);
            end
        end
    endtask

    task automatic test_timeout();
        step_t s;
        logic [27:0] obs;
        gen(7'd6, 1'b0, MW, 0);
        gen(7'd6, 1'b0, MW - 1, 0);
        gen(7'd7, 1'b0, 0, MW);
        gen(7'd13, 1'b0, 0, MW);
        gen(7'd13, 1'b0, 0, MW - 1);
        while (q.size() > 0) begin
            s = q.pop_front();
            step_dut(s, obs);
            checks++;
            if (obs !== {s.st, s.ctl, s.code}) begin
                errors++;
                $display("FAIL timeout: got st=%0d ctl=%b code=%0d want st=%0d ctl=%b code=%0d",
                         obs[27:21], obs[20:7], obs[6:0], s.st, s.ctl, s.code);
            end
        end
    endtask

    task automatic test_branch_jr();
        step_t s;
        logic [27:0] obs;
        gen(7'd41, 1'b1, 0, 0);
        gen(7'd41, 1'b0, 0, 0);
        gen(7'd11, 1'b1, 1, 0);
        gen(7'd44, 1'b0, 0, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            step_dut(s, obs);
            checks++;
            if (obs !== {s.st, s.ctl, s.code}) begin
                errors++;
                $display("FAIL branch: got st=%0d ctl=%b code=%0d want st=%0d ctl=%b code=%0d",
                         obs[27:21], obs[20:7], obs[6:0], s.st, s.ctl, s.code);
            end
        end
    endtask

    task automatic test_illegal();
        step_t s;
        logic [27:0] obs;
        gen(7'd1, 1'b0, 0, 0);
        gen(7'd50, 1'b0, 0, 0);
        gen(7'd45, 1'b0, 0, 0);
        gen(7'd6, 1'b0, 0, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            step_dut(s, obs);
            checks++;
            if (obs !== {s.st, s.ctl, s.code}) begin
                errors++;
                $display("FAIL illegal: got st=%0d ctl=%b code=%0d want st=%0d ctl=%b code=%0d",
                         obs[27:21], obs[20:7], obs[6:0], s.st, s.ctl, s.code);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        logic [27:0] obs;
        logic [6:0] sel;
        int wf, wm;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: sel = 7'd6;
                1: sel = 7'(17 + $urandom_range(0, 18));
                2: sel = 7'd7;
                3: sel = 7'd13;
                4: begin
                    sel = 7'd11;
                    case ($urandom_range(0, 3))
                        0: sel = 7'd37;
                        1: sel = 7'd39;
                        2: sel = 7'd41;
                        default: sel = 7'd42;
                    endcase
                end
                5: sel = 7'd44;
                default: begin
                    sel = rs();
                    while (kind(sel) != 0) sel = rs();
                end
            endcase
            wf = ($urandom_range(0, 7) == 0) ? MW : $urandom_range(0, MW - 1);
            wm = ($urandom_range(0, 7) == 0) ? MW : $urandom_range(0, MW - 1);
            gen(sel, rb(), wf, wm);
        end
        while (q.size() > 0) begin
            s = q.pop_front();
            step_dut(s, obs);
            checks++;
            if (obs !== {s.st, s.ctl, s.code}) begin
                errors++;
                $display("FAIL random: got st=%0d ctl=%b code=%0d want st=%0d ctl=%b code=%0d",
                         obs[27:21], obs[20:7], obs[6:0], s.st, s.ctl, s.code);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s;
        logic [27:0] obs;
        int seen, keep;
        gen(7'd7, 1'b0, 0, MW + 3);
        seen = 0;
        keep = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].st == 7'd8) begin
                seen++;
                if (seen == 2 && keep == q.size()) keep = i + 1;
            end
        end
        while (q.size() > keep) void'(q.pop_back());
        pend_be = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            step_dut(s, obs);
            checks++;
            if (obs !== {s.st, s.ctl, s.code}) begin
                errors++;
                $display("FAIL midrst_pre: got st=%0d ctl=%b code=%0d want st=%0d ctl=%b code=%0d",
                         obs[27:21], obs[20:7], obs[6:0], s.st, s.ctl, s.code);
            end
        end
        MOC = 1'b0;
        checks++;
        if (State !== 7'd8) begin
            errors++;
            $display("FAIL midrst_wait: st=%0d want 8", State);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({State, act_ctl, Exec_Code} !== 28'd0) begin
            errors++;
            $display("FAIL midrst_async: st=%0d ctl=%b code=%0d want all 0",
                     State, act_ctl, Exec_Code);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_code = '0;
        pend_ill = 0;
        pend_be = 0;
        @(posedge Clk);
        #1;
        gen(7'd6, 1'b0, MW - 1, 0);
        while (q.size() > 0) begin
            s = q.pop_front();
            step_dut(s, obs);
            checks++;
            if (obs !== {s.st, s.ctl, s.code}) begin
                errors++;
                $display("FAIL midrst_post: got st=%0d ctl=%b code=%0d want st=%0d ctl=%b code=%0d",
                         obs[27:21], obs[20:7], obs[6:0], s.st, s.ctl, s.code);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_timeout();
        test_branch_jr();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
